// File: rtl/rx_polar_averager.sv
// Window averager for the RX rect-to-polar stream: mean magnitude, wrap-safe
// circular mean phase and mean phase step over 2^k samples, one strobe per window.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no window open, waiting for the first enabled sample
// ST_ACCUM | window partially filled (1 <= count < N)
// ST_DONE  | Nth sample just accepted, result entering the pipeline
module rx_polar_averager #(
    parameter int MW   = 16,
    parameter int PW   = 25,
    parameter int KMAX = 10
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic [3:0]           i_avg_log2,
    input  logic                 i_valid,
    input  logic signed [MW-1:0] i_mag,
    input  logic [PW-1:0]        i_phase,
    output logic                 o_valid,
    output logic [MW-1:0]        o_mag_avg,
    output logic [PW-1:0]        o_phase_avg,
    output logic signed [PW-1:0] o_freq,
    output logic                 o_busy
);

    localparam int AMW = MW + KMAX;
    localparam int UW  = PW + KMAX;
    localparam int SW  = PW + 2 * KMAX;
    localparam int CW  = KMAX + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    k_q, k_d;
    logic          nd_q, nd_d;

    logic          accept;
    logic [3:0]    k_clamp;
    logic [3:0]    win_k;
    logic [CW-1:0] n_win;
    logic          is_last;
    logic [MW-1:0] mag_c;

    assign accept  = i_valid & i_enable;
    assign k_clamp = (i_avg_log2 > 4'(KMAX)) ? 4'(KMAX) : i_avg_log2;
    assign win_k   = (cnt_q == '0) ? k_clamp : k_q;
    assign n_win   = CW'(1) << win_k;
    assign is_last = (cnt_q + CW'(1)) == n_win;
    assign mag_c   = i_mag[MW-1] ? '0 : i_mag;
    assign o_busy  = (state_q == ST_ACCUM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        nd_d    = nd_q;
        if (!i_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            nd_d    = 1'b1;
        end else if (accept) begin
            nd_d = 1'b0;
            if (cnt_q == '0) begin
                k_d = k_clamp;
            end
            if (is_last) begin
                cnt_d   = '0;
                state_d = ST_DONE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = ST_ACCUM;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    // Stage A: registered accepted sample with its window-position tags
    logic          a_vld_q, a_first_q, a_last_q, a_dz_q;
    logic [MW-1:0] a_mag_q;
    logic [PW-1:0] a_ph_q;
    logic [3:0]    a_k_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            nd_q      <= 1'b1;
            a_vld_q   <= 1'b0;
            a_first_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_dz_q    <= 1'b0;
            a_mag_q   <= '0;
            a_ph_q    <= '0;
            a_k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            nd_q    <= nd_d;
            a_vld_q <= accept;
            if (accept) begin
                a_mag_q   <= mag_c;
                a_ph_q    <= i_phase;
                a_first_q <= (cnt_q == '0);
                a_last_q  <= is_last;
                a_k_q     <= win_k;
                a_dz_q    <= nd_q;
            end
        end
    end

    // Stage B: phase step and accumulation; u is the unwrapped offset from p0
    logic [PW-1:0]        prev_ph_q, p0_q, f_p0_q;
    logic signed [UW-1:0] u_q, sd_q, f_sd_q;
    logic signed [SW-1:0] su_q, f_su_q;
    logic [AMW-1:0]       sm_q, f_sm_q;
    logic [3:0]           f_k_q;
    logic                 f_vld_q;

    logic signed [PW-1:0] d_b;
    logic signed [UW-1:0] d_ext, u_n, sd_n;
    logic signed [SW-1:0] su_n;
    logic [AMW-1:0]       sm_n;
    logic [PW-1:0]        p0_n;

    always_comb begin
        d_b   = a_dz_q ? '0 : signed'(a_ph_q - prev_ph_q);
        d_ext = {{KMAX{d_b[PW-1]}}, d_b};
        if (a_first_q) begin
            u_n  = '0;
            su_n = '0;
            sd_n = d_ext;
            sm_n = {{KMAX{1'b0}}, a_mag_q};
            p0_n = a_ph_q;
        end else begin
            u_n  = u_q + d_ext;
            su_n = su_q + {{KMAX{u_n[UW-1]}}, u_n};
            sd_n = sd_q + d_ext;
            sm_n = sm_q + {{KMAX{1'b0}}, a_mag_q};
            p0_n = p0_q;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ph_q <= '0;
            p0_q      <= '0;
            u_q       <= '0;
            su_q      <= '0;
            sd_q      <= '0;
            sm_q      <= '0;
            f_vld_q   <= 1'b0;
            f_p0_q    <= '0;
            f_su_q    <= '0;
            f_sd_q    <= '0;
            f_sm_q    <= '0;
            f_k_q     <= '0;
        end else begin
            f_vld_q <= a_vld_q & a_last_q;
            if (a_vld_q) begin
                prev_ph_q <= a_ph_q;
                p0_q      <= p0_n;
                u_q       <= u_n;
                su_q      <= su_n;
                sd_q      <= sd_n;
                sm_q      <= sm_n;
                if (a_last_q) begin
                    f_p0_q <= p0_n;
                    f_su_q <= su_n;
                    f_sd_q <= sd_n;
                    f_sm_q <= sm_n;
                    f_k_q  <= a_k_q;
                end
            end else if (!i_enable) begin
                u_q  <= '0;
                su_q <= '0;
                sd_q <= '0;
                sm_q <= '0;
            end
        end
    end

    // Stage C: floor shifts, re-add p0, register results
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid     <= 1'b0;
            o_mag_avg   <= '0;
            o_phase_avg <= '0;
            o_freq      <= '0;
        end else begin
            o_valid <= f_vld_q;
            if (f_vld_q) begin
                o_mag_avg   <= MW'(f_sm_q >> f_k_q);
                o_phase_avg <= f_p0_q + PW'(f_su_q >>> f_k_q);
                o_freq      <= PW'(f_sd_q >>> f_k_q);
            end
        end
    end

endmodule

// File: tb/tb_rx_polar_averager.sv
// Randomized + directed bench for rx_polar_averager against a window-list model.
module tb_rx_polar_averager;

    localparam longint FULL = 64'd1 << 25;
    localparam longint MASK = FULL - 1;
    localparam longint HALF = FULL >> 1;

    logic               sys_clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_enable = 1'b0;
    logic [3:0]         i_avg_log2 = '0;
    logic               i_valid = 1'b0;
    logic signed [15:0] i_mag = '0;
    logic [24:0]        i_phase = '0;
    logic               o_valid;
    logic [15:0]        o_mag_avg;
    logic [24:0]        o_phase_avg;
    logic signed [24:0] o_freq;
    logic               o_busy;

    rx_polar_averager #(.MW(16), .PW(25), .KMAX(10)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .i_enable(i_enable), .i_avg_log2(i_avg_log2),
        .i_valid(i_valid), .i_mag(i_mag), .i_phase(i_phase), .o_valid(o_valid),
        .o_mag_avg(o_mag_avg), .o_phase_avg(o_phase_avg), .o_freq(o_freq), .o_busy(o_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_res = 0;
    longint cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        longint due;
        longint mag;
        longint ph;
        longint fr;
    } res_t;
    res_t exp_q[$];

    // Reference model: collect each window's samples, evaluate the averages at window end
    longint w_ph[$];
    longint w_d[$];
    longint w_m[$];
    longint prev_ph;
    bit     have_prev;
    int     m_k;

    initial begin
        forever begin
            @(posedge sys_clk or negedge rst_n);
            if (!rst_n) begin
                w_ph.delete(); w_d.delete(); w_m.delete(); exp_q.delete();
                have_prev = 0;
                prev_ph = 0;
            end else begin
                cyc++;
                if (!i_enable) begin
                    w_ph.delete(); w_d.delete(); w_m.delete();
                    have_prev = 0;
                end else if (i_valid) begin
                    longint d, ph;
                    ph = longint'(i_phase);
                    d = 0;
                    if (have_prev) begin
                        d = (ph - prev_ph) & MASK;
                        if (d >= HALF) d -= FULL;
                    end
                    have_prev = 1;
                    prev_ph = ph;
                    if (w_ph.size() == 0) m_k = (i_avg_log2 > 10) ? 10 : int'(i_avg_log2);
                    w_ph.push_back(ph);
                    w_d.push_back(d);
                    w_m.push_back((i_mag < 0) ? 0 : longint'(i_mag));
                    if (w_ph.size() == (1 << m_k)) begin
                        res_t r;
                        longint sm, sd, u, su;
                        sm = 0; sd = 0; u = 0; su = 0;
                        foreach (w_m[i]) sm += w_m[i];
                        foreach (w_d[i]) sd += w_d[i];
                        for (int i = 1; i < w_d.size(); i++) begin
                            u += w_d[i];
                            su += u;
                        end
                        r.due = cyc + 2;
                        r.mag = sm >> m_k;
                        r.ph  = (w_ph[0] + (su >>> m_k)) & MASK;
                        r.fr  = (sd >>> m_k) & MASK;
                        exp_q.push_back(r);
                        w_ph.delete(); w_d.delete(); w_m.delete();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (rst_n) begin
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    check("result_late", cyc, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
                if (o_valid) begin
                    n_res++;
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", exp_q.size(), 1);
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        check("valid_cycle", cyc, e.due);
                        check("mag_avg", o_mag_avg, e.mag);
                        check("phase_avg", o_phase_avg, e.ph);
                        check("freq", {o_freq}, e.fr);
                    end
                end
            end
        end
    end

    task automatic drive(input logic en, input logic vld, input logic [3:0] k,
                         input int mag, input int ph);
        @(negedge sys_clk);
        i_enable = en;
        i_valid = vld;
        i_avg_log2 = k;
        i_mag = 16'(mag);
        i_phase = 25'(ph);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            i_valid = 1'b0;
        end
    endtask

    initial begin
        int ph;
        int res0;
        repeat (3) @(negedge sys_clk);
        check("rst_valid", o_valid, 0);
        check("rst_mag", o_mag_avg, 0);
        check("rst_phase", o_phase_avg, 0);
        check("rst_freq", {o_freq}, 0);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        idle(2);

        // N = 1 passthrough
        drive(1, 1, 0, 1000, 25'h0ABCDEF);
        idle(3);
        check("n1_valid", o_valid, 1);
        check("n1_mag", o_mag_avg, 1000);
        check("n1_phase", o_phase_avg, 25'h0ABCDEF);
        check("n1_freq", {o_freq}, 0);
        idle(1);
        check("n1_pulse_width", o_valid, 0);
        check("n1_hold", o_mag_avg, 1000);

        // Phase wrap, first d after enable rise is zero
        drive(0, 0, 1, 0, 0);
        drive(1, 1, 1, 10, 25'h1FFFF00);
        drive(1, 1, 1, 20, 25'h0000100);
        check("wrap_busy_mid", o_busy, 1);
        idle(1);
        check("wrap_busy_end", o_busy, 0);
        idle(2);
        check("wrap_valid", o_valid, 1);
        check("wrap_phase", o_phase_avg, 0);
        check("wrap_freq", {o_freq}, 25'h100);

        // Ramps across several wraps, back-to-back windows
        ph = 0;
        for (int i = 0; i < 64; i++) begin
            drive(1, 1, 4, 500 + i, ph);
            ph = (ph + 32'h100000) & int'(MASK);
        end
        idle(3);
        check("ramp_up_freq", {o_freq}, 25'h100000);
        for (int i = 0; i < 64; i++) begin
            drive(1, 1, 4, 800, ph);
            ph = (ph - 32'h100000) & int'(MASK);
        end
        idle(3);
        check("ramp_dn_freq", {o_freq}, 25'h1F00000);

        // Magnitude clamp
        drive(1, 1, 2, 100, 0);
        drive(1, 1, 2, -50, 0);
        drive(1, 1, 2, 300, 0);
        drive(1, 1, 2, 201, 0);
        idle(3);
        check("clamp_mag", o_mag_avg, 150);

        // Abort mid-window
        res0 = n_res;
        for (int i = 0; i < 5; i++) drive(1, 1, 3, 40 * i + 7, 25'h123456 * (i + 1));
        drive(0, 1, 3, 999, 25'h1555555);
        drive(1, 0, 3, 0, 0);
        check("abort_busy", o_busy, 0);
        idle(4);
        check("abort_no_result", n_res, res0);
        for (int i = 0; i < 8; i++) drive(1, 1, 3, 300 + i, 25'h0F0F0F * (i + 3));
        idle(4);
        check("abort_one_result", n_res, res0 + 1);

        // Nth sample followed by enable drop still delivers
        drive(1, 1, 1, 60, 25'h10);
        drive(1, 1, 1, 70, 25'h30);
        drive(0, 0, 1, 0, 0);
        idle(2);
        check("late_disable_valid", o_valid, 1);

        // Reset mid-window, then k change mid-window
        drive(1, 1, 2, 123, 25'h4000);
        drive(1, 1, 2, 456, 25'h5000);
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", o_valid, 0);
        check("mrst_mag", o_mag_avg, 0);
        check("mrst_phase", o_phase_avg, 0);
        check("mrst_freq", {o_freq}, 0);
        check("mrst_busy", o_busy, 0);
        idle(2);
        rst_n = 1'b1;
        res0 = n_res;
        drive(1, 1, 2, 11, 25'h100);
        drive(1, 1, 2, 22, 25'h300);
        drive(1, 1, 0, 33, 25'h700);
        drive(1, 1, 0, 44, 25'hF00);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 55 + i, 25'h1000 * i);
        idle(4);
        check("kchg_results", n_res, res0 + 4);

        // Largest window, k above KMAX clamps to 1024 samples
        res0 = n_res;
        for (int i = 0; i < 1024; i++)
            drive(1, 1, 15, int'(16'($urandom)), int'($urandom & 32'h1FFFFFF));
        idle(4);
        check("kmax_results", n_res, res0 + 1);

        // Random traffic with mid-window k changes, gaps and aborts
        for (int i = 0; i < 2500; i++)
            drive(($urandom_range(0, 29) != 0), ($urandom_range(0, 9) < 7),
                  4'($urandom_range(0, 4)), int'(16'($urandom)),
                  int'($urandom & 32'h1FFFFFF));
        drive(1, 0, 0, 0, 0);
        idle(6);
        check("pending_results", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
